// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit async SRAM between an ifetch and a data port.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed data-port priority; default is round-robin.
module sram_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 20,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_be,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]           sram_wr_data,
  input  logic [15:0]           sram_rd_data
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [4:0] STRB_OFF = 5'b11111;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    gnt_d_q;
  logic                    we_q;
  logic [ADDR_WIDTH-2:0]   waddr_q;
  logic [1:0]              hbe_q;
  logic [15:0]             whi_q;
  logic [15:0]             lo_q;
  logic [4:0]              strb_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wr_q;
  logic                    i_ack_q;
  logic                    d_ack_q;
  logic [DATA_WIDTH-1:0]   i_rd_q;
  logic [DATA_WIDTH-1:0]   d_rd_q;

  logic                    pick_d;
  logic                    sel_we;
  logic [ADDR_WIDTH-2:0]   sel_addr;
  logic                    unused_msb;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick_d = d_req;
`else
  logic last_d_q;
  assign pick_d = d_req & (~i_req | ~last_d_q);
`endif

  assign sel_we     = pick_d & d_we;
  assign sel_addr   = pick_d ? d_addr[ADDR_WIDTH-2:0]
                             : i_addr[ADDR_WIDTH-2:0];
  assign unused_msb = i_addr[ADDR_WIDTH-1] ^ d_addr[ADDR_WIDTH-1];

  // {ce_n, oe_n, we_n, ub_n, lb_n}; a write with no enables idles the chip
  function automatic logic [4:0] phase_strb(logic we, logic [1:0] en);
    if (!we)         return 5'b00100;
    if (en == 2'b00) return STRB_OFF;
    return {3'b010, ~en[1], ~en[0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_d_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      hbe_q   <= '0;
      whi_q   <= '0;
      lo_q    <= '0;
      strb_q  <= STRB_OFF;
      addr_q  <= '0;
      wr_q    <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_rd_q  <= '0;
      d_rd_q  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_d_q <= 1'b1;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            state_q <= LO;
            cnt_q   <= '0;
            gnt_d_q <= pick_d;
            we_q    <= sel_we;
            waddr_q <= sel_addr;
            hbe_q   <= d_be[3:2];
            whi_q   <= d_wr_data[31:16];
            strb_q  <= phase_strb(sel_we, d_be[1:0]);
            addr_q  <= {sel_addr, 1'b0};
            wr_q    <= d_wr_data[15:0];
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_d_q <= pick_d;
`endif
          end
        end
        LO: begin
          if (cnt_q == LAST) begin
            if (!we_q) lo_q <= sram_rd_data;
            state_q <= HI;
            cnt_q   <= '0;
            strb_q  <= phase_strb(we_q, hbe_q);
            addr_q  <= {waddr_q, 1'b1};
            wr_q    <= whi_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HI: begin
          if (cnt_q == LAST) begin
            state_q <= RESP;
            strb_q  <= STRB_OFF;
            if (!we_q && gnt_d_q)  d_rd_q <= {sram_rd_data, lo_q};
            if (!we_q && !gnt_d_q) i_rd_q <= {sram_rd_data, lo_q};
            d_ack_q <= gnt_d_q;
            i_ack_q <= ~gnt_d_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} = strb_q;
  assign sram_addr    = addr_q;
  assign sram_wr_data = wr_q;
  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign i_rd_data    = i_rd_q;
  assign d_rd_data    = d_rd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random and directed checks of sram_arbiter against
// a word-level memory model and a served-last arbitration model.
module tb_sram_arbiter;

  localparam int AW  = 20;
  localparam int AC  = 2;
  localparam int LAT = 2 * AC + 1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_rd_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wr_data;
  logic          d_ack;
  logic [31:0]   d_rd_data;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wr_data;
  logic [15:0]   sram_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem  [0:4095];
  logic [31:0] refm [0:2047];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a  = '0;
  logic [15:0] pl_d  = '0;
  logic [31:0] exp_ird, exp_drd;

  always #5 clk = ~clk;

  sram_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rd_data(i_rd_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wr_data(d_wr_data), .d_ack(d_ack), .d_rd_data(d_rd_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_addr(sram_addr),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
  );

  // async SRAM: combinational read, byte-masked write on each strobed edge
  assign sram_rd_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  <= sram_wr_data[7:0];
      if (!sram_ub_n) mem[sram_addr[11:0]][15:8] <= sram_wr_data[15:8];
    end
  end

  task automatic preload(input int w, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_a = 12'(2 * w); pl_d = v[15:0];
    @(negedge clk);
    pl_a = 12'(2 * w + 1); pl_d = v[31:16];
    @(negedge clk);
    pl_en = 1'b0;
    refm[w] = v;
  endtask

  task automatic run_tx(input bit pd, input bit we, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output int bad);
    int            ph;
    logic [1:0]    ben;
    logic [AW-1:0] ea;
    logic [15:0]   half;
    bit            ok;
    bit            rdw;
    rdw = pd && we;
    lat = -1; bad = 0; rd = '0;
    @(negedge clk);
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wr_data = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    @(posedge clk);
    for (int n = 1; n <= 2 * LAT && lat < 0; n++) begin
      @(negedge clk);
      if (pd && n == 1) begin
        d_we = 1'($urandom); d_addr = AW'($urandom);
        d_be = 4'($urandom); d_wr_data = $urandom;
      end
      ph   = (n <= AC) ? 0 : 1;
      ea   = {a[AW-2:0], ph[0]};
      ben  = be[2*ph +: 2];
      half = (ph == 0) ? wd[15:0] : wd[31:16];
      if (n > 2 * AC)
        ok = (sram_ce_n === 1'b1);
      else if (!rdw)
        ok = ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} === 5'b00100)
             && (sram_addr === ea);
      else if (ben == 2'b00)
        ok = (sram_ce_n === 1'b1) && (sram_we_n === 1'b1);
      else
        ok = ({sram_ce_n, sram_oe_n, sram_we_n} === 3'b010)
             && (sram_ub_n === ~ben[1]) && (sram_lb_n === ~ben[0])
             && (sram_addr === ea) && (sram_wr_data === half);
      if (!ok) bad++;
      if ((pd ? i_ack : d_ack) !== 1'b0) bad++;
      if ((pd ? d_ack : i_ack) === 1'b1) begin
        lat = n;
        rd  = pd ? d_rd_data : i_rd_data;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    if (rdw) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) refm[a[10:0]][8*b +: 8] = wd[8*b +: 8];
    end else if (pd) exp_drd = refm[a[10:0]];
    else exp_ird = refm[a[10:0]];
    @(negedge clk);
    if (i_ack !== 1'b0 || d_ack !== 1'b0) bad++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 11111",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    n_checks++;
    if (sram_addr !== '0 || sram_wr_data !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr %0h wdata %0h expected 0", sram_addr, sram_wr_data);
    end
    n_checks++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack: i %b d %b expected 0", i_ack, d_ack);
    end
    n_checks++;
    if (i_rd_data !== '0 || d_rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rdata: i %0h d %0h expected 0", i_rd_data, d_rd_data);
    end
  endtask

  task automatic test_ifetch();
    int lat, bad;
    logic [31:0] rd;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 20'h00010 : 20'h80010;
      run_tx(1'b0, 1'b0, a, 4'h0, 32'h0, lat, rd, bad);
      n_checks++;
      if (lat != LAT) begin
        n_fail++; $display("FAIL ifetch_latency: got %0d expected %0d", lat, LAT);
      end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL ifetch_data: got %h expected deadbeef", rd);
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL ifetch_strobes: %0d bad cycles expected 0", bad);
      end
    end
  endtask

  task automatic test_write_read();
    int lat, bad;
    logic [31:0] rd;
    preload(4, 32'hA5A55A5A);
    run_tx(1'b1, 1'b0, 20'h00004, 4'hF, 32'h0, lat, rd, bad);
    n_checks++;
    if (rd !== 32'hA5A55A5A) begin
      n_fail++; $display("FAIL wr_preread: got %h expected a5a55a5a", rd);
    end
    run_tx(1'b1, 1'b1, 20'h00004, 4'hF, 32'h12345678, lat, rd, bad);
    n_checks++;
    if (lat != LAT || bad != 0) begin
      n_fail++; $display("FAIL wr_cycle: lat %0d bad %0d expected %0d/0", lat, bad, LAT);
    end
    n_checks++;
    if (mem[8] !== 16'h5678 || mem[9] !== 16'h1234) begin
      n_fail++; $display("FAIL wr_halves: got %h/%h expected 5678/1234", mem[8], mem[9]);
    end
    n_checks++;
    if (d_rd_data !== 32'hA5A55A5A) begin
      n_fail++; $display("FAIL wr_rd_hold: got %h expected a5a55a5a", d_rd_data);
    end
    n_checks++;
    if (i_rd_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_i_hold: got %h expected deadbeef", i_rd_data);
    end
    run_tx(1'b1, 1'b0, 20'h00004, 4'hF, 32'h0, lat, rd, bad);
    n_checks++;
    if (rd !== 32'h12345678 || lat != LAT) begin
      n_fail++; $display("FAIL wr_readback: got %h lat %0d expected 12345678 lat %0d", rd, lat, LAT);
    end
  endtask

  task automatic test_byte_enable();
    int lat, bad;
    logic [31:0] rd;
    preload(5, 32'h11223344);
    run_tx(1'b1, 1'b1, 20'h00005, 4'b0011, 32'hCAFEF00D, lat, rd, bad);
    n_checks++;
    if (lat != LAT) begin
      n_fail++; $display("FAIL be_latency: got %0d expected %0d", lat, LAT);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL be_strobes: %0d bad cycles expected 0", bad);
    end
    n_checks++;
    if (mem[11] !== 16'h1122) begin
      n_fail++; $display("FAIL be_hi_untouched: got %h expected 1122", mem[11]);
    end
    run_tx(1'b1, 1'b0, 20'h00005, 4'h0, 32'h0, lat, rd, bad);
    n_checks++;
    if (rd !== 32'h1122F00D) begin
      n_fail++; $display("FAIL be_readback: got %h expected 1122f00d", rd);
    end
  endtask

  task automatic test_pending();
    int ki, kd;
    logic [31:0] ri, rdd;
    ki = -1; kd = -1; ri = '0; rdd = '0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 20'h00003;
    @(posedge clk);
    for (int k = 1; k <= 40 && (ki < 0 || kd < 0); k++) begin
      @(negedge clk);
      if (k == 2) begin d_req = 1'b1; d_we = 1'b0; d_addr = 20'h0000C; end
      if (i_ack === 1'b1 && ki < 0) begin ki = k; ri = i_rd_data; end
      if (d_ack === 1'b1 && kd < 0) begin kd = k; rdd = d_rd_data; end
      @(posedge clk); #1;
      if (ki == k) i_req = 1'b0;
      if (kd == k) d_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (ki != LAT || ri !== refm[3]) begin
      n_fail++; $display("FAIL pend_first: at %0d data %h expected %0d %h", ki, ri, LAT, refm[3]);
    end
    n_checks++;
    if (kd != 2 * LAT + 1) begin
      n_fail++; $display("FAIL pend_second_time: got %0d expected %0d", kd, 2 * LAT + 1);
    end
    n_checks++;
    if (rdd !== refm[12]) begin
      n_fail++; $display("FAIL pend_second_data: got %h expected %h", rdd, refm[12]);
    end
    exp_ird = refm[3];
    exp_drd = refm[12];
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bad;
    logic [31:0] rd, ex, wd;
    logic [AW-1:0] a;
    logic [3:0] be;
    bit pd, we;
    for (int t = 0; t < 24; t++) begin
      pd = 1'($urandom_range(0, 1));
      we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a[AW-1] = 1'b1;
      be = 4'($urandom);
      wd = $urandom;
      ex = refm[a[10:0]];
      run_tx(pd, we, a, be, wd, lat, rd, bad);
      n_checks++;
      if (lat != LAT || bad != 0) begin
        n_fail++; $display("FAIL rand_cycle[%0d]: lat %0d bad %0d expected %0d/0", t, lat, bad, LAT);
      end
      if (!we) begin
        n_checks++;
        if (rd !== ex) begin
          n_fail++; $display("FAIL rand_read[%0d]: got %h expected %h", t, rd, ex);
        end
      end
      n_checks++;
      if (i_rd_data !== exp_ird || d_rd_data !== exp_drd) begin
        n_fail++; $display("FAIL rand_hold[%0d]: got %h/%h expected %h/%h",
          t, i_rd_data, d_rd_data, exp_ird, exp_drd);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat, bad, acks;
    logic [31:0] rd;
    @(negedge clk);
    i_req = 1'b1; i_addr = 20'h00010;
    @(posedge clk);
    repeat (AC + 1) @(negedge clk);
    n_checks++;
    if (sram_ce_n !== 1'b0 || sram_addr !== 20'h00021) begin
      n_fail++; $display("FAIL abort_in_hi: ce_n %b addr %h expected 0 00021", sram_ce_n, sram_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      n_fail++; $display("FAIL abort_async_strobes: got %b expected 11111",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ird = '0; exp_drd = '0;
    acks = 0;
    repeat (3 * LAT) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks);
    end
    n_checks++;
    if (i_rd_data !== '0) begin
      n_fail++; $display("FAIL abort_rdata: got %h expected 0", i_rd_data);
    end
    run_tx(1'b0, 1'b0, 20'h00010, 4'h0, 32'h0, lat, rd, bad);
    n_checks++;
    if (lat != LAT || rd !== refm[16] || bad != 0) begin
      n_fail++; $display("FAIL abort_rerequest: lat %0d data %h bad %0d expected %0d %h 0",
        lat, rd, bad, LAT, refm[16]);
    end
  endtask

  task automatic test_back_to_back();
    int nack, exp_k;
    bit last_d, exp_d;
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b1; i_addr = 20'h00007;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00009;
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
    nack = 0;
    for (int k = 1; k <= 6 * LAT && nack < 4; k++) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        exp_d  = FIXED ? 1'b1 : !last_d;
        last_d = exp_d;
        exp_k  = LAT + nack * (LAT + 1);
        n_checks++;
        if ((i_ack & d_ack) !== 1'b0 || d_ack !== exp_d) begin
          n_fail++; $display("FAIL b2b_order[%0d]: i %b d %b expected d=%b", nack, i_ack, d_ack, exp_d);
        end
        n_checks++;
        if (k != exp_k) begin
          n_fail++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", nack, k, exp_k);
        end
        n_checks++;
        if (exp_d ? (d_rd_data !== refm[9]) : (i_rd_data !== refm[7])) begin
          n_fail++; $display("FAIL b2b_data[%0d]: i %h d %h expected %h", nack,
            i_rd_data, d_rd_data, exp_d ? refm[9] : refm[7]);
        end
        nack++;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (nack != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d acks expected 4", nack);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wr_data = '0;
    exp_ird = '0; exp_drd = '0;
    for (int w = 0; w < 32; w++) preload(w, $urandom);
    preload(16, 32'hDEADBEEF);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_ifetch();
    test_write_read();
    test_byte_enable();
    test_pending();
    test_random();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
